spi_cmd_ctrl: RTL

Command sequencer behind the SPI byte receiver. It runs in the system clock domain and consumes the synchronized byte stream: one strobe plus data per byte, and a frame select. It decodes a small framed protocol (opcode, address, payload) into framebuffer write requests and control-register writes for the VGA core. It owns framing, address auto-increment, write back-pressure and error reporting.

---
 rtl/vga_spi_pkg.sv | 23 ++
 rtl/spi_wr_skid.sv | 57 +++++
 rtl/spi_cmd_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vga_spi_pkg.sv
// Shared definitions for the SPI command path feeding the VGA core:
// protocol opcodes, command sequencer states and the address byte count.
package vga_spi_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_MEM_WR = 8'h01;
  localparam logic [7:0] OP_REG_WR = 8'h02;

  // Framebuffer addresses always arrive as this many bytes, high byte first.
  localparam int ADDR_BYTES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPCODE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_MEM_DATA,
    S_REG_IDX,
    S_REG_VAL,
    S_DISCARD
  } state_t;

endpackage

// File: rtl/spi_wr_skid.sv
// Framebuffer write port with a one-entry holding register. It owns the
// MemWe/MemReady handshake; a byte arriving while both the output and the
// holding slot are occupied is flagged as an overflow and dropped.
module spi_wr_skid (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic       o_we,
  output logic [7:0] o_data,
  output logic       o_accept,
  output logic       o_overflow
);

  logic       r_we;
  logic [7:0] r_data;
  logic       r_sk_vld;
  logic [7:0] r_sk_data;

  assign o_we       = r_we;
  assign o_data     = r_data;
  assign o_accept   = r_we & i_ready;
  assign o_overflow = i_push & r_we & ~i_ready & r_sk_vld;

  // Output slot and skid slot: refill the output from the skid on acceptance,
  // park a new byte in the skid while the output is stalled.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_we      <= 1'b0;
      r_data    <= 8'h00;
      r_sk_vld  <= 1'b0;
      r_sk_data <= 8'h00;
    end else if (!r_we) begin
      if (i_push) begin
        r_we   <= 1'b1;
        r_data <= i_data;
      end
    end else if (i_ready) begin
      if (r_sk_vld) begin
        r_data   <= r_sk_data;
        r_sk_vld <= i_push;
        if (i_push) begin
          r_sk_data <= i_data;
        end
      end else if (i_push) begin
        r_data <= i_data;
      end else begin
        r_we <= 1'b0;
      end
    end else if (i_push && !r_sk_vld) begin
      r_sk_vld  <= 1'b1;
      r_sk_data <= i_data;
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind the SPI byte receiver. Decodes framed
// opcode/address/payload byte streams into framebuffer writes (with address
// auto-increment and back-pressure) and control-register write strobes.
module spi_cmd_ctrl
  import vga_spi_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int NREGS_LOG2 = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  CSel,
  input  logic                  ByteValid,
  input  logic [7:0]            ByteIn,
  input  logic                  MemReady,
  output logic                  MemWe,
  output logic [ADDR_W-1:0]     MemAddr,
  output logic [7:0]            MemData,
  output logic                  RegWe,
  output logic [NREGS_LOG2-1:0] RegAddr,
  output logic [7:0]            RegData,
  output logic                  Busy,
  output logic                  Err
);

  state_t                  r_state;
  logic                    r_err;
  logic                    r_reg_we;
  logic [NREGS_LOG2-1:0]   r_reg_addr;
  logic [7:0]              r_reg_data;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic [7:0]              r_addr_hi;

  logic                    w_push;
  logic                    w_accept;
  logic                    w_overflow;
  logic                    w_mem_we;
  logic [7:0]              w_mem_data;
  logic [8*ADDR_BYTES-1:0] w_addr_full;

  assign w_push      = (r_state == S_MEM_DATA) && ByteValid;
  assign w_addr_full = {r_addr_hi, ByteIn};

  spi_wr_skid u_skid (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_push     (w_push),
    .i_data     (ByteIn),
    .i_ready    (MemReady),
    .o_we       (w_mem_we),
    .o_data     (w_mem_data),
    .o_accept   (w_accept),
    .o_overflow (w_overflow)
  );

  // Frame decoder: state, sticky error, register strobe and write address.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_err      <= 1'b0;
      r_reg_we   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= 8'h00;
      r_mem_addr <= '0;
      r_addr_hi  <= 8'h00;
    end else begin
      r_reg_we <= 1'b0;
      if (w_accept) begin
        r_mem_addr <= r_mem_addr + ADDR_W'(1);
      end
      if (w_overflow) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (!CSel) begin
            r_state <= S_OPCODE;
            r_err   <= 1'b0;
          end
        end
        S_OPCODE: begin
          if (ByteValid) begin
            case (ByteIn)
              OP_NOP:    r_state <= S_OPCODE;
              OP_MEM_WR: r_state <= S_ADDR_HI;
              OP_REG_WR: r_state <= S_REG_IDX;
              default: begin
                r_state <= S_DISCARD;
                r_err   <= 1'b1;
              end
            endcase
          end
        end
        S_ADDR_HI: begin
          if (ByteValid) begin
            r_addr_hi <= ByteIn;
            r_state   <= S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (ByteValid) begin
            r_mem_addr <= w_addr_full[ADDR_W-1:0];
            r_state    <= S_MEM_DATA;
          end
        end
        S_MEM_DATA: begin
          r_state <= S_MEM_DATA;
        end
        S_REG_IDX: begin
          if (ByteValid) begin
            r_reg_addr <= ByteIn[NREGS_LOG2-1:0];
            r_state    <= S_REG_VAL;
          end
        end
        S_REG_VAL: begin
          if (ByteValid) begin
            r_reg_data <= ByteIn;
            r_reg_we   <= 1'b1;
            r_state    <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          r_state <= S_DISCARD;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // Frame end wins over the byte-driven transition; the byte itself
      // was still processed above.
      if (CSel && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign MemWe   = w_mem_we;
  assign MemAddr = r_mem_addr;
  assign MemData = w_mem_data;
  assign RegWe   = r_reg_we;
  assign RegAddr = r_reg_addr;
  assign RegData = r_reg_data;
  assign Err     = r_err;
  assign Busy    = (r_state != S_IDLE) || w_mem_we;

endmodule
